// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types, HD44780 command codes and timing defaults for the LCD bus arbiter.
package lcd_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, EN_HI, EXEC} state_e;
  typedef enum logic {HALF_LOW, HALF_HIGH} half_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0F;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam int T_SETUP_DEF = 40000;
  localparam int T_EN_DEF    = 100000;
  localparam int T_EXEC_DEF  = 40000;
  localparam int T_CLR_DEF   = 200000;
  localparam int CW_DEF      = 32;

  // Clear and home (0x03 is home with the don't-care bit set) need the long wait.
  function automatic logic is_slow_cmd(input logic [7:0] b);
    return (b == CMD_CLEAR) || (b == CMD_HOME) || (b == (CMD_HOME | 8'h01));
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD pin bundle; slave side belongs to the arbiter.
interface lcd_bus_arbiter_if #(parameter int NREQ = 3);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_rs;
  logic [NREQ-1:0]   req_nib;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic              busy;
  logic [2:0]        owner;
  logic [3:0]        data;
  logic              rs;
  logic              rw;
  logic              en;

  modport master (
    output req_valid, req_data, req_rs, req_nib, req_lock,
    input  req_ready, req_done, busy, owner, data, rs, rw, en
  );

  modport slave (
    input  req_valid, req_data, req_rs, req_nib, req_lock,
    output req_ready, req_done, busy, owner, data, rs, rw, en
  );

endinterface

// File: rtl/lcd_bus_arbiter_rr.sv
// Combinational round-robin grant; a held lock restricts eligibility to the owner.
module lcd_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [2:0]      ptr,
  input  logic            lock_active,
  input  logic [2:0]      owner,
  output logic [2:0]      grant,
  output logic            grant_valid
);

  int best_d;
  int d;

  // Pick the valid requester closest to ptr going upward with wrap.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    best_d      = NREQ;
    d           = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(ptr)) % NREQ;
      if (lock_active) begin
        if (valid[i] && (owner == 3'(i))) begin
          grant       = 3'(i);
          grant_valid = 1'b1;
        end
      end else if (valid[i] && (d < best_d)) begin
        best_d      = d;
        grant       = 3'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one 4-bit HD44780 bus between requesters, serialising bytes into timed nibble strobes.
module lcd_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_EN    = T_EN_DEF,
  parameter int T_EXEC  = T_EXEC_DEF,
  parameter int T_CLR   = T_CLR_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic           clk,
  input  logic           nrst,
  lcd_bus_arbiter_if.slave bus
);

  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(T_EN - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(T_CLR - 1);

  state_e          state, state_n;
  half_e           half;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   exec_last;
  logic [7:0]      byte_q;
  logic            rs_q, nib_q, lock_q, lock_active;
  logic [2:0]      owner_q, rr_ptr, next_ptr;
  logic [3:0]      data_q;
  logic            rs_out, en_q;
  logic [NREQ-1:0] done_q, done_vec, ready_vec;
  logic [2:0]      grant;
  logic            grant_valid, take;
  logic [7:0]      sel_byte;
  logic            sel_rs, sel_nib, sel_lock;

  lcd_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid       (bus.req_valid),
    .ptr         (rr_ptr),
    .lock_active (lock_active),
    .owner       (owner_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign next_ptr = (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;

  // No grant in the cycle carrying req_done, leaving one idle cycle between transfers.
  always_comb begin
    state_n   = state;
    take      = 1'b0;
    exec_last = (!rs_q && !nib_q && is_slow_cmd(byte_q)) ? CLR_LAST : EXEC_LAST;
    unique case (state)
      IDLE:    if (grant_valid && (done_q == '0)) begin
                 take    = 1'b1;
                 state_n = SETUP;
               end
      SETUP:   if (cnt == SETUP_LAST) state_n = EN_HI;
      EN_HI:   if (cnt == EN_LAST)
                 state_n = (half == HALF_HIGH && !nib_q) ? SETUP : EXEC;
      EXEC:    if (cnt == exec_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_byte  = '0;
    sel_rs    = 1'b0;
    sel_nib   = 1'b0;
    sel_lock  = 1'b0;
    ready_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == 3'(i)) begin
        sel_byte     = bus.req_data[8*i +: 8];
        sel_rs       = bus.req_rs[i];
        sel_nib      = bus.req_nib[i];
        sel_lock     = bus.req_lock[i];
        ready_vec[i] = take;
      end
      if (owner_q == 3'(i)) done_vec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      half        <= HALF_HIGH;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      nib_q       <= 1'b0;
      lock_q      <= 1'b0;
      lock_active <= 1'b0;
      owner_q     <= '0;
      rr_ptr      <= '0;
      data_q      <= '0;
      rs_out      <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= '0;
    end else begin
      state  <= state_n;
      cnt    <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
      en_q   <= (state_n == EN_HI);
      done_q <= '0;
      if (take) begin
        byte_q  <= sel_byte;
        rs_q    <= sel_rs;
        nib_q   <= sel_nib;
        lock_q  <= sel_lock;
        owner_q <= grant;
        rr_ptr  <= next_ptr;
        rs_out  <= sel_rs;
        data_q  <= sel_nib ? sel_byte[3:0] : sel_byte[7:4];
        half    <= sel_nib ? HALF_LOW : HALF_HIGH;
      end
      if (state == EN_HI && state_n == SETUP) begin
        data_q <= byte_q[3:0];
        half   <= HALF_LOW;
      end
      if (state == EXEC && state_n == IDLE) begin
        done_q      <= done_vec;
        lock_active <= lock_q;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.req_done  = done_q;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = owner_q;
  assign bus.data      = data_q;
  assign bus.rs        = rs_out;
  assign bus.rw        = 1'b0;
  assign bus.en        = en_q;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single 4-bit HD44780 LCD bus between up to NREQ requesters (init sequencer, text writer, cursor/browse controller).
- Each accepted request is one byte or one nibble. The block serialises it into nibble strobes with the fixed setup, enable-high and execution delays, so requesters never drive data/rs/en directly.
- Arbitration is round-robin, with an optional lock so a requester can hold the bus across a multi-byte sequence (e.g. set DDRAM address, then write a character).
- Sits between the requester FSMs and the top-level LCD pins.

Parameters:
- NREQ, 3, number of requesters (2..8)
- T_SETUP, 40000, cycles data/rs are stable before en rises (400 us at 100 MHz)
- T_EN, 100000, cycles en stays high (1 ms)
- T_EXEC, 40000, post-byte wait for normal commands/data (400 us)
- T_CLR, 200000, post-byte wait for clear/home commands (2 ms)
- CW, 32, delay counter width

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i]
- req_rs  in  NREQ  0 = command, 1 = data
- req_nib  in  NREQ  1 = send only req_data[3:0] as a single nibble (8-bit-mode init)
- req_lock  in  NREQ  keep the bus for this requester after the transfer
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester
- req_done  out  NREQ  one-cycle pulse when the transfer's wait period ends
- busy  out  1  high from accept until return to IDLE
- owner  out  3  index of the current/last grant
- data  out  4  LCD D7..D4
- rs  out  1  LCD register select
- rw  out  1  LCD read/write, tied 0
- en  out  1  LCD enable

Behaviour:
- Reset (asynchronous, active-low) forces all outputs to 0 in the same instant:
  - data, rs, rw, en, req_ready, req_done, busy = 0
  - owner = 0, lock_active = 0, rr pointer = 0
  - A transfer in progress is dropped; en falls immediately.
- States: IDLE, SETUP, EN_HI, EXEC.
- IDLE, grant selection:
  - If lock_active, only the owner is eligible.
  - Otherwise the first asserted req_valid at or after index (owner+1) mod NREQ, wrapping.
- IDLE, on grant:
  - Pulse req_ready[g] that cycle.
  - Latch byte, rs, nib and lock into internal registers.
  - Set owner = g and busy = 1.
  - Go to SETUP with half = (nib ? LOW : HIGH).
- SETUP: data = latched half nibble, rs = latched rs, en = 0. Stay T_SETUP cycles, then go to EN_HI.
- EN_HI: en = 1 for T_EN cycles. Then en = 0 and:
  - if half == HIGH and nib == 0: half = LOW, go to SETUP;
  - otherwise go to EXEC.
- EXEC:
  - Wait T_CLR if rs == 0 and nib == 0 and byte in {0x01, 0x02, 0x03}; otherwise wait T_EXEC.
  - Then pulse req_done[owner], set lock_active = latched lock, busy = 0, go to IDLE.
- Timing: a byte transfer occupies 1 + 2*(T_SETUP+T_EN) + wait cycles from accept to done; a nibble occupies 1 + T_SETUP + T_EN + wait.
- data and rs hold their last value in IDLE and EXEC; they change only on entry to SETUP.
- The delay counter resets to 0 on every state change. Compare is "count == T-1", so each state lasts exactly T cycles.
- Handshake:
  - req_valid must stay high until req_ready.
  - Inputs other than the granted requester's are ignored during busy.
  - Dropping valid before ready is legal; the requester simply loses its turn.
- Back-to-back: a new grant may be issued in the IDLE cycle immediately after req_done (one idle cycle minimum between transfers).
- Lock:
  - The owner with lock_active and req_valid = 0 holds the bus indefinitely; other requesters stall.
  - The lock is released only by completing a transfer with req_lock = 0.
- Simultaneous valids: the round-robin order is deterministic. A requester never wins twice in a row while another is pending, unless lock is active.
- rw is constant 0; no busy-flag reads.

Decomposition:
- Package lcd_bus_pkg:
  - state encoding (IDLE, SETUP, EN_HI, EXEC);
  - HD44780 command constants (CLEAR 0x01, HOME 0x02, ENTRY 0x06, DISP_ON 0x0F, SET_DDRAM 0x80);
  - timing defaults.
- One natural sub-module: lcd_rr_arbiter, the combinational round-robin with lock mask (inputs valid, pointer, lock_active, owner; output grant index and grant_valid).
- Nibble timing FSM and delay counter stay in the top.

Test Plan:
All scenarios use T_SETUP=2, T_EN=3, T_EXEC=2, T_CLR=10.
- Single byte: req0 sends rs=1, 0x4D ('M') → ready pulse; data=0x4 during the first en-high (3 cycles), then 0x5 during the second; rs=1 throughout; done 13 cycles after ready.
- Clear: req1 sends rs=0, 0x01 → nibbles 0x0, 0x1; EXEC lasts 10 cycles; done 21 cycles after ready.
- Nibble init: req0 sends nib=1, data 0x03 → exactly one en pulse with data=0x3; done 8 cycles after ready.
- Round-robin: req0, req1, req2 all valid continuously → grants in order 0, 1, 2, 0; no requester is granted twice while another waits.
- Lock: req2 sends 0x80|0x40 with lock=1, while req0 is valid → next grant goes to req2 (0x41 data) even with req0 pending; req0 is granted only after req2 completes a transfer with lock=0.
- Reset mid-transfer: assert nrst=0 during EN_HI → en, busy, data, rs go 0 asynchronously; after release, no done pulse and the bus is IDLE.
